// File: rtl/output_tensor_writer.sv
// Output tensor writer: turns the streamed int8 results into NHWC byte addresses,
// buffers them in a small FIFO and issues byte-enabled 32-bit RAM writes over req/gnt.
module output_tensor_writer #(
  parameter int MAX_N           = 64,
  parameter int N_BITS          = $clog2(MAX_N),
  parameter int MAX_NUM_CH      = 64,
  parameter int CH_BITS         = $clog2(MAX_NUM_CH + 1),
  parameter int BYPASS_IDX_BITS = 6,
  parameter int ADDR_W          = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_load,
  input  logic [N_BITS:0]            cfg_img_width,
  input  logic [CH_BITS-1:0]         cfg_num_ch,
  input  logic [ADDR_W-1:0]          cfg_base_addr,
  input  logic                       cfg_bypass,
  input  logic [CH_BITS-1:0]         cur_channel,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  input  logic [N_BITS-1:0]          in_row,
  input  logic [N_BITS-1:0]          in_col,
  input  logic [BYPASS_IDX_BITS-1:0] in_index,
  input  logic                       flush,
  output logic                       mem_req,
  output logic [ADDR_W-3:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  input  logic                       mem_gnt,
  output logic                       flush_done,
  output logic                       idle,
  output logic                       overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE} state_t;

  state_t              state_reg;
  logic [N_BITS:0]     cfg_width_reg;
  logic [CH_BITS-1:0]  cfg_num_ch_reg;
  logic [ADDR_W-1:0]   cfg_base_reg;
  logic                cfg_bypass_reg;

  logic                s1_v_reg;
  logic [ADDR_W-1:0]   s1_pix_reg;
  logic [7:0]          s1_data_reg;
  logic [CH_BITS-1:0]  s1_ch_reg;
  logic                s2_v_reg;
  logic [ADDR_W-1:0]   s2_addr_reg;
  logic [7:0]          s2_data_reg;

  logic [ADDR_W-1:0]   fifo_addr_mem [FIFO_DEPTH];
  logic [7:0]          fifo_data_mem [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr_reg;
  logic [PTR_W:0]      rd_ptr_reg;
  logic                overflow_reg;
  logic                flush_done_reg;

  logic [ADDR_W-1:0]   pix_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [PTR_W:0]      fifo_count;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop;
  logic                push;
  logic                drain_clear;
  logic [ADDR_W-1:0]   head_addr;
  logic [7:0]          head_data;

  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && mem_gnt;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts when draining.
  assign push       = s2_v_reg && (!fifo_full || pop);

  // The last pending word leaving this cycle already counts as drained.
  assign drain_clear = !s1_v_reg && !s2_v_reg && !in_valid &&
                       (fifo_empty || (fifo_count == (PTR_W + 1)'(1) && pop));

  assign idle = !s1_v_reg && !s2_v_reg && fifo_empty && (state_reg == ST_IDLE);

  always_comb begin
    pix_next = ADDR_W'(in_index);
    if (!cfg_bypass_reg)
      pix_next = ADDR_W'(in_row) * ADDR_W'(cfg_width_reg) + ADDR_W'(in_col);
  end

  always_comb begin
    addr_next = cfg_base_reg + s1_pix_reg;
    if (!cfg_bypass_reg)
      addr_next = cfg_base_reg + s1_pix_reg * ADDR_W'(cfg_num_ch_reg) + ADDR_W'(s1_ch_reg);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_reg[PTR_W-1:0]] <= s2_addr_reg;
      fifo_data_mem[wr_ptr_reg[PTR_W-1:0]] <= s2_data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cfg_width_reg  <= '0;
      cfg_num_ch_reg <= '0;
      cfg_base_reg   <= '0;
      cfg_bypass_reg <= 1'b0;
      s1_v_reg       <= 1'b0;
      s1_pix_reg     <= '0;
      s1_data_reg    <= '0;
      s1_ch_reg      <= '0;
      s2_v_reg       <= 1'b0;
      s2_addr_reg    <= '0;
      s2_data_reg    <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      overflow_reg   <= 1'b0;
      flush_done_reg <= 1'b0;
    end else begin
      if (cfg_load && idle) begin
        cfg_width_reg  <= cfg_img_width;
        cfg_num_ch_reg <= cfg_num_ch;
        cfg_base_reg   <= cfg_base_addr;
        cfg_bypass_reg <= cfg_bypass;
      end
      s1_v_reg    <= in_valid;
      s1_pix_reg  <= pix_next;
      s1_data_reg <= in_data;
      s1_ch_reg   <= cur_channel;
      s2_v_reg    <= s1_v_reg;
      s2_addr_reg <= addr_next;
      s2_data_reg <= s1_data_reg;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (s2_v_reg && !push) overflow_reg <= 1'b1;

      flush_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE:  if (flush) state_reg <= ST_DRAIN;
        ST_DRAIN: if (drain_clear) begin
          state_reg      <= ST_DONE;
          flush_done_reg <= 1'b1;
        end
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  assign overflow_err = overflow_reg;
  assign flush_done   = flush_done_reg;

  assign head_addr = fifo_addr_mem[rd_ptr_reg[PTR_W-1:0]];
  assign head_data = fifo_data_mem[rd_ptr_reg[PTR_W-1:0]];
  assign mem_req   = !fifo_empty;
  assign mem_addr  = fifo_empty ? '0 : head_addr[ADDR_W-1:2];
  assign mem_be    = fifo_empty ? 4'b0000 : (4'b0001 << head_addr[1:0]);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign mem_wdata[8*gi +: 8] = fifo_empty ? 8'h00 : head_data;
    end
  endgenerate

endmodule
